// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: register map,
// status bit positions and FSM state encoding.
package uart_sched_pkg;

    localparam logic [31:0] UART_CTRL   = 32'h0;
    localparam logic [31:0] UART_STATUS = 32'h4;
    localparam logic [31:0] UART_BAUD   = 32'h8;
    localparam logic [31:0] UART_TXDATA = 32'hC;

    localparam int TX_BUSY_BIT = 0;

    typedef enum logic [2:0] {
        INIT_BAUD,
        INIT_CTRL,
        IDLE,
        POLL,
        WRITE
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld
);

    logic [N-1:0][W-1:0] cand;

    // cand[i] is the channel i positions after ptr, modulo N.
    for (genvar i = 0; i < N; i++) begin : g_cand
        assign cand[i] = ((int'(ptr) + i) >= N) ? W'(int'(ptr) + i - N)
                                                 : W'(int'(ptr) + i);
    end

    // Scan from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                grant_idx = cand[i];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ byte producers.
// Programs BAUD/CTRL after reset, then arbitrates, polls busy, writes TXDATA.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int          NUM_REQ  = 4,
    parameter logic [31:0] BAUD_DIV = 32'h1B8,
    parameter logic        RX_EN    = 1'b0,
    localparam int         GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_we_o,
    output logic [31:0]          uart_addr_o,
    output logic [31:0]          uart_data_o,
    input  logic [31:0]          uart_data_i,
    output logic                 init_done_o,
    output logic [GW-1:0]        grant_o
);

    sched_state_e  state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] arb_idx;
    logic          arb_vld;
    logic [7:0]    tx_byte;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_BAUD;
            rr_ptr      <= '0;
            grant_o     <= '0;
            tx_byte     <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                INIT_BAUD: state <= INIT_CTRL;
                INIT_CTRL: begin
                    init_done_o <= 1'b1;
                    state       <= IDLE;
                end
                // Grant and byte are frozen here until WRITE completes.
                IDLE: if (arb_vld) begin
                    grant_o <= arb_idx;
                    tx_byte <= req_data_i[{arb_idx, 3'b000} +: 8];
                    state   <= POLL;
                end
                POLL: if (!uart_data_i[TX_BUSY_BIT]) state <= WRITE;
                WRITE: begin
                    rr_ptr <= (grant_o == GW'(NUM_REQ - 1)) ? '0 : grant_o + GW'(1);
                    state  <= IDLE;
                end
                default: state <= INIT_BAUD;
            endcase
        end
    end

    // Bus outputs decode the state register; rst masks them so the UART port
    // stays quiet while reset is held.
    always_comb begin
        uart_we_o   = 1'b0;
        uart_addr_o = '0;
        uart_data_o = '0;
        req_ready_o = '0;
        if (!rst) begin
            case (state)
                INIT_BAUD: begin
                    uart_we_o   = 1'b1;
                    uart_addr_o = UART_BAUD;
                    uart_data_o = BAUD_DIV;
                end
                INIT_CTRL: begin
                    uart_we_o   = 1'b1;
                    uart_addr_o = UART_CTRL;
                    uart_data_o = {30'b0, RX_EN, 1'b1};
                end
                IDLE, POLL: uart_addr_o = UART_STATUS;
                WRITE: begin
                    uart_we_o            = 1'b1;
                    uart_addr_o          = UART_TXDATA;
                    uart_data_o          = {24'b0, tx_byte};
                    req_ready_o[grant_o] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed stimulus pushes expected UART
// writes; a negedge monitor pops and compares every write the DUT issues.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic          uart_we;
    logic [31:0]   uart_addr, uart_wdata, uart_rdata;
    logic          init_done;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_len = 3;
    int busy_cnt = 0;
    int wr_cnt[NR] = '{default: 0};
    logic prev_we = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ch;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(NR), .BAUD_DIV(32'h1B8), .RX_EN(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .uart_we_o   (uart_we),
        .uart_addr_o (uart_addr),
        .uart_data_o (uart_wdata),
        .uart_data_i (uart_rdata),
        .init_done_o (init_done),
        .grant_o     (grant)
    );

    // UART model: busy for busy_len cycles after each TXDATA write.
    assign uart_rdata = (uart_addr == UART_STATUS) ? {31'b0, busy_cnt != 0} : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_we && uart_addr == UART_TXDATA) busy_cnt <= busy_len;
        else if (busy_cnt != 0)                  busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input int ch);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.ch   = ch;
        expq.push_back(e);
    endtask

    task automatic push_init();
        push(UART_BAUD, 32'h1B8, -1);
        push(UART_CTRL, 32'h1, -1);
    endtask

    // Wait for channel ch's ready pulse, then drop its valid for the next IDLE.
    task automatic wait_ready(input int ch, input int budget, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -1;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = req_ready[ch];
        end
        at_cyc = cyc;
        chk($sformatf("ready_ch%0d", ch), 32'(seen), 32'd1);
        @(posedge clk);
        #1 req_valid[ch] = 1'b0;
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (uart_we) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", uart_addr, 32'hDEAD_BEEF);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", uart_addr, e.addr);
                chk("wr_data", uart_wdata, e.data);
                chk("wr_ready", 32'(req_ready), (e.ch >= 0) ? 32'(1 << e.ch) : 32'd0);
            end
            if (uart_addr == UART_TXDATA) begin
                chk("no_b2b_we", 32'(prev_we), 32'd0);
                chk("not_busy_at_write", 32'(busy_cnt), 32'd0);
                for (int k = 0; k < NR; k++) if (req_ready[k]) wr_cnt[k]++;
            end
        end else if (req_ready != '0) begin
            chk("stray_ready", 32'(req_ready), 32'd0);
        end
        prev_we = uart_we;
    end

    initial begin
        int w1, w2, got;
        int snap[NR];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(uart_we), 32'd0);
        chk("rst_addr", uart_addr, 32'd0);
        chk("rst_data", uart_wdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);

        // Init sequence: BAUD, CTRL, then init_done from cycle 3
        push_init();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("init_done_c1", 32'(init_done), 32'd0);
        @(negedge clk); chk("init_done_c2", 32'(init_done), 32'd0);
        @(negedge clk); chk("init_done_c3", 32'(init_done), 32'd1);

        // Single byte on ch2; UART stays busy 1000 cycles after this write
        busy_len = 1000;
        push(UART_TXDATA, 32'h55, 2);
        req_data[23:16] = 8'h55;
        req_valid[2]    = 1'b1;
        @(negedge clk);
        chk("lat_poll_ready", 32'(req_ready), 32'd0);
        chk("lat_poll_grant", 32'(grant), 32'd2);
        @(negedge clk);
        chk("lat_write_ready", 32'(req_ready), 32'b0100);
        w1 = cyc;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        busy_len = 60;

        // Busy hold-off: ch0 must wait for STATUS to clear (1002 cycles after write 1)
        push(UART_TXDATA, 32'hA5, 0);
        req_data[7:0] = 8'hA5;
        req_valid[0]  = 1'b1;
        wait_ready(0, 1100, w2);
        chk("holdoff_gap", 32'(w2 - w1), 32'd1002);

        // Reset mid-transfer: ch1 granted and stuck in POLL
        req_data[15:8] = 8'h77;
        req_valid[1]   = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_grant", 32'(grant), 32'd1);
        chk("mid_ready", 32'(req_ready), 32'd0);
        push_init();
        push(UART_TXDATA, 32'h77, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_ready(1, 200, w2);

        // Fairness: all channels valid after a fresh reset, 100 transfers
        busy_len = 2;
        push_init();
        for (int i = 0; i < 100; i++) push(UART_TXDATA, 32'hA0 + 32'(i % NR), i % NR);
        for (int k = 0; k < NR; k++) snap[k] = wr_cnt[k];
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < NR; k++) req_data[8*k +: 8] = 8'hA0 + 8'(k);
        req_valid = '1;
        @(posedge clk);
        #1 rst = 1'b0;
        got = 0;
        for (int n = 0; n < 2000 && got < 100; n++) begin
            @(negedge clk);
            if (req_ready != '0) got++;
        end
        chk("fair_total", 32'(got), 32'd100);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < NR; k++)
            chk($sformatf("fair_ch%0d", k), 32'(wr_cnt[k] - snap[k]), 32'd25);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
